// File: rtl/cpu_cu.sv
// cpu_cu: control unit for the CPU execution unit.
// Runs FETCH -> DECODE -> EXEC for each instruction, or FETCH -> DECODE -> HALT
// for opcode F. All control outputs are decoded combinationally from the state
// register and IR.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RESET  | after reset: all enables low; always goes to FETCH next
//   FETCH  | M[PC] -> IR, PC++
//   DECODE | opcode in IR is examined; F goes to HALT, anything else to EXEC
//   EXEC   | one control word for the instruction, then back to FETCH
//   HALT   | absorbing; halted=1; only reset leaves it
module cpu_cu #(
  parameter logic [3:0] ALU_PASS_S = 4'h0,
  parameter logic [3:0] ALU_PASS_R = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        reg_w_en,
  output logic        S_Sel,
  output logic        adr_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  ALU_OP,
  output logic        mr_en,
  output logic        mw_en,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] instr_cnt
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_LDI  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_BRZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [3:0] opcode;
  logic [2:0] next_state;
  logic       retire;

  // C, N and IR[11:9] carry nothing this block acts on.
  logic unused_inputs;
  assign unused_inputs = ^{C, N, IR[11:9]};

  assign opcode = IR[15:12];
  assign W_Adr  = IR[8:6];
  assign R_Adr  = IR[5:3];
  assign S_Adr  = IR[2:0];

  // An instruction retires on the edge leaving EXEC, or on the edge into HALT.
  assign retire = (state == S_EXEC) || ((state == S_DECODE) && (opcode == OP_HALT));

  // Next-state selection.
  always_comb begin
    next_state = S_RESET;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_RESET;
    endcase
  end

  // State register; reset wins from every state.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= next_state;
  end

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)       instr_cnt <= 16'h0000;
    else if (retire) instr_cnt <= instr_cnt + 16'h0001;
  end

  // Control word decode from state and opcode.
  always_comb begin
    reg_w_en = 1'b0;
    S_Sel    = 1'b0;
    adr_sel  = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    mr_en    = 1'b0;
    mw_en    = 1'b0;
    halted   = 1'b0;
    ALU_OP   = 4'h0;
    case (state)
      S_FETCH: begin
        mr_en  = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_LD: begin
            adr_sel  = 1'b1;
            mr_en    = 1'b1;
            S_Sel    = 1'b1;
            ALU_OP   = ALU_PASS_S;
            reg_w_en = 1'b1;
          end
          OP_ST: begin
            adr_sel = 1'b1;
            ALU_OP  = ALU_PASS_S;
            mw_en   = 1'b1;
          end
          OP_LDI: begin
            mr_en    = 1'b1;
            S_Sel    = 1'b1;
            ALU_OP   = ALU_PASS_S;
            reg_w_en = 1'b1;
            pc_inc   = 1'b1;
          end
          OP_JMP: begin
            ALU_OP = ALU_PASS_R;
            pc_ld  = 1'b1;
          end
          OP_BRZ: begin
            ALU_OP = ALU_PASS_R;
            pc_ld  = Z;
          end
          OP_HALT: begin
            // Unreachable: DECODE routes opcode F to HALT.
          end
          default: begin
            // Opcodes 0-9 are plain ALU operations.
            ALU_OP   = opcode;
            reg_w_en = 1'b1;
          end
        endcase
      end
      S_HALT: halted = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_cu.sv
// tb_cpu_cu: directed test of cpu_cu against an instruction-level model.
module tb_cpu_cu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        C = 1'b0, N = 1'b0, Z = 1'b0;
  logic        reg_w_en, S_Sel, adr_sel, pc_ld, pc_inc, ir_ld, mr_en, mw_en, halted;
  logic [2:0]  W_Adr, R_Adr, S_Adr, state;
  logic [3:0]  ALU_OP;
  logic [15:0] instr_cnt;

  int checks = 0;
  int passed = 0;

  cpu_cu dut (
    .clk(clk), .reset(reset), .IR(IR), .C(C), .N(N), .Z(Z),
    .reg_w_en(reg_w_en), .S_Sel(S_Sel), .adr_sel(adr_sel), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .ir_ld(ir_ld), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .ALU_OP(ALU_OP), .mr_en(mr_en), .mw_en(mw_en), .halted(halted),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Model: phase numbers are the architectural state codes (0..4).
  int          m_phase = 0;
  logic [15:0] m_cnt = 16'h0000;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_cnt   = 16'h0000;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0: m_phase = 1;
        1: m_phase = 2;
        2: if (IR[15:12] == 4'hF) begin m_phase = 4; m_cnt = m_cnt + 16'd1; end
           else m_phase = 3;
        3: begin m_phase = 1; m_cnt = m_cnt + 16'd1; end
        default: m_phase = 4;
      endcase
    end
  end

  // Expected {reg_w_en,S_Sel,adr_sel,pc_ld,pc_inc,ir_ld,mr_en,mw_en,halted,ALU_OP}.
  function automatic logic [12:0] exp_ctrl(int ph, logic [15:0] ir, logic z);
    logic rw, ss, ad, pl, pi, il, mr, mw, h;
    logic [3:0] op;
    logic [3:0] alu;
    {rw, ss, ad, pl, pi, il, mr, mw, h} = '0;
    alu = 4'h0;
    op  = ir[15:12];
    if (ph == 1) begin
      mr = 1; il = 1; pi = 1;
    end else if (ph == 4) begin
      h = 1;
    end else if (ph == 3) begin
      if (op <= 4'd9) begin alu = op; rw = 1; end
      else if (op == 4'hA) begin ad = 1; mr = 1; ss = 1; rw = 1; alu = 4'h0; end
      else if (op == 4'hB) begin ad = 1; mw = 1; alu = 4'h0; end
      else if (op == 4'hC) begin mr = 1; ss = 1; rw = 1; pi = 1; alu = 4'h0; end
      else if (op == 4'hD) begin pl = 1; alu = 4'h1; end
      else if (op == 4'hE) begin pl = z; alu = 4'h1; end
    end
    return {rw, ss, ad, pl, pi, il, mr, mw, h, alu};
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [40:0] got, want;
    if (m_valid) begin
      got  = {reg_w_en, S_Sel, adr_sel, pc_ld, pc_inc, ir_ld, mr_en, mw_en, halted,
              ALU_OP, state, W_Adr, R_Adr, S_Adr, instr_cnt};
      want = {exp_ctrl(m_phase, IR, Z), 3'(m_phase), IR[8:6], IR[5:3], IR[2:0], m_cnt};
      checks++;
      if (got === want) passed++;
      else $display("FAIL cycle t=%0t got=%h want=%h", $time, got, want);
    end
  end

  task automatic lit(string name, logic [15:0] actual, logic [15:0] want);
    checks++;
    if (actual === want) passed++;
    else $display("FAIL %s got=%h want=%h", name, actual, want);
  endtask

  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Runs one full instruction starting from FETCH, ending back in FETCH.
  task automatic run(logic [15:0] ir);
    IR = ir;
    step(3);
  endtask

  initial begin
    step(3);
    lit("rst_state", 16'(state), 16'd0);
    lit("rst_cnt", instr_cnt, 16'd0);
    lit("rst_en", 16'({reg_w_en, S_Sel, adr_sel, pc_ld, pc_inc, ir_ld, mr_en, mw_en, halted}), 16'd0);
    reset = 0;
    step(1);
    lit("fetch_state", 16'(state), 16'd1);
    lit("fetch_en", 16'({mr_en, ir_ld, pc_inc, adr_sel}), 16'b1110);

    IR = 16'h304A;
    step(1);
    lit("alu_decode", 16'(state), 16'd2);
    step(1);
    lit("alu_exec", 16'({ALU_OP, reg_w_en, W_Adr, R_Adr, S_Adr}), 16'({4'd3, 1'b1, 3'd1, 3'd1, 3'd2}));
    step(1);
    lit("alu_back", 16'(state), 16'd1);
    lit("alu_cnt", instr_cnt, 16'd1);

    IR = 16'hA0C8; step(2);
    lit("ld_exec", 16'({adr_sel, mr_en, S_Sel, reg_w_en, ALU_OP, W_Adr, R_Adr}), 16'b1111_0000_011_001);
    step(1);
    IR = 16'hB00A; step(2);
    lit("st_exec", 16'({mw_en, reg_w_en, adr_sel, R_Adr, S_Adr}), 16'b101_001_010);
    step(1);
    IR = 16'hC080; step(2);
    lit("ldi_exec", 16'({pc_inc, mr_en, S_Sel, reg_w_en, adr_sel, W_Adr}), 16'b11110_010);
    step(1);
    IR = 16'hE008; Z = 1; step(2);
    lit("brz_taken", 16'({pc_ld, ALU_OP}), 16'b1_0001);
    step(1);
    Z = 0; step(2);
    lit("brz_not", 16'({pc_ld, ALU_OP}), 16'b0_0001);
    step(1);
    lit("brz_next", 16'(state), 16'd1);
    lit("cnt6", instr_cnt, 16'd6);

    IR = 16'h1000; step(2);
    reset = 1; step(2);
    lit("midexec_rst", 16'({instr_cnt, state}), 16'd0);
    reset = 0; step(1);

    run(16'h1111); run(16'h2222); run(16'h9FFF);
    IR = 16'hF000; step(2);
    lit("halt_state", 16'(state), 16'd4);
    lit("halt_flag", 16'(halted), 16'd1);
    lit("halt_cnt", instr_cnt, 16'd4);
    IR = 16'h3000; step(12);
    lit("halt_stay", 16'({halted, state}), 16'b1_100);

    reset = 1; step(2);
    lit("halt_rst", 16'({instr_cnt, state}), 16'd0);
    reset = 0; step(1);

    IR = 16'h2000; step(2);
    force dut.instr_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1 release dut.instr_cnt;
    step(1);
    lit("wrap", instr_cnt, 16'h0000);
    step(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
